// File: rtl/recon_pkg.sv
// Shared types and constants for the dividend reconstructor.
// Optional consistency check is enabled with RECON_CHECK_EN.
package recon_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int cnt_width(
    input int w
  );
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/recon_datapath.sv
// Shift-and-add multiplier plus final remainder adder.
// Driven by load/step/add strobes from the control FSM.
module recon_datapath
  import recon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               load,
  input  logic               step,
  input  logic               add,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] dividend,
  output logic               last
);

  localparam int CW = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem_r;
  logic [CW-1:0]      count;

  // Final step of the multiply: count goes to zero on this edge
  assign last = (count == CW'(1));

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem_r    <= '0;
      count    <= '0;
      dividend <= '0;
    end else begin
      if (load) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, divisor};
        mplier <= quotient;
        rem_r  <= remainder;
        count  <= CW'(WIDTH);
      end else if (step) begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
      end
      if (add)
        dividend <= acc + {{WIDTH{1'b0}}, rem_r};
    end
  end

endmodule

// File: rtl/dividend_reconstructor.sv
// Rebuilds Dividend = Quotient*Divisor + Remainder.
// Define RECON_CHECK_EN to add the Error consistency output.
module dividend_reconstructor
  import recon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Go,
  input  logic [WIDTH-1:0]   Divisor,
  input  logic [WIDTH-1:0]   Quotient,
  input  logic [WIDTH-1:0]   Remainder,
`ifdef RECON_CHECK_EN
  output logic               Error,
`endif
  output logic [2*WIDTH-1:0] Dividend,
  output logic               Busy,
  output logic               Done
);

  state_t state;
  logic   load;
  logic   step;
  logic   add;
  logic   last;

  assign load = (state == IDLE) && Go;
  assign step = (state == MULT);
  assign add  = (state == ADD);

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (Go) state <= MULT;
        MULT: if (last) state <= ADD;
        ADD:  state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state == MULT) || (state == ADD);
  assign Done = (state == DONE);

`ifdef RECON_CHECK_EN
  logic flag;

  always_ff @(posedge Clock) begin
    if (!Resetn)
      flag <= 1'b0;
    else if (load)
      flag <= (Divisor == '0) || (Remainder >= Divisor);
  end

  assign Error = Done && flag;
`endif

  recon_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .load      (load),
    .step      (step),
    .add       (add),
    .divisor   (Divisor),
    .quotient  (Quotient),
    .remainder (Remainder),
    .dividend  (Dividend),
    .last      (last)
  );

endmodule

// File: doc/dividend_reconstructor.md
Name: dividend_reconstructor

Overview:
Inverse of the lab divider: takes a divide result (Quotient, Remainder) and the Divisor, and rebuilds Dividend = Quotient*Divisor + Remainder.
- Multi-cycle shift-and-add multiplier, then one add cycle; Go/Busy/Done handshake.
- Used as a round-trip checker behind the divider and as a standalone lab exercise.

Parameters:
WIDTH, 4, operand width in bits; Dividend output is 2*WIDTH bits.

Ports:
Clock  input  1  system clock, all state updates on rising edge
Resetn  input  1  reset
Go  input  1  start request, sampled only in IDLE
Divisor  input  WIDTH  divisor operand
Quotient  input  WIDTH  quotient operand
Remainder  input  WIDTH  remainder operand
Dividend  output  2*WIDTH  reconstructed dividend, registered
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle completion pulse
Interface rule: reset Resetn, synchronous, active-low; clock Clock.

Behaviour:
- Reset (Resetn low at a rising edge): state=IDLE; Dividend=0, Busy=0, Done=0; internal acc, multiplicand, multiplier and counter cleared. Reset has priority over everything, including mid-operation; the operation is abandoned.
- States: IDLE, MULT, ADD, DONE.
- IDLE: at an edge with Go=1, capture the operands:
  - multiplicand = zero-extended Divisor (2*WIDTH bits)
  - multiplier = Quotient
  - rem_r = Remainder
  - acc = 0, count = WIDTH
  - go to MULT.
- Inputs are not sampled again until the next start; changes during an operation have no effect.
- MULT: each edge:
  - if multiplier[0], acc += multiplicand
  - multiplicand <<= 1; multiplier >>= 1; count -= 1
  - when count reaches 0 on this edge, go to ADD. Exactly WIDTH cycles.
- ADD: Dividend <= acc + zero-extended rem_r; go to DONE.
- DONE: Done=1 for exactly this cycle; next edge go to IDLE unconditionally.
- Busy = 1 in MULT and ADD; 0 in IDLE and DONE. Done = 1 only in DONE. Both decoded from the state register (glitch-free, no input paths).
- Latency: if Go is sampled at edge N, Dividend updates and Done rises after edge N+WIDTH+1, and Done falls after edge N+WIDTH+2.
- The earliest next start is edge N+WIDTH+3, so back-to-back throughput is one result per WIDTH+3 cycles.
- Go while Busy or in DONE: ignored, not queued.
- Width: 2*WIDTH bits always suffices, since max = (2^W-1)^2 + (2^W-1) < 2^(2W). No overflow and no truncation.
- Divisor=0: legal; result = Remainder.
- Quotient=0: result = Remainder; still takes the full WIDTH+2 cycles, with no early exit.
- Dividend holds its value between operations until the next ADD or a reset.

Optional Feature:
Macro RECON_CHECK_EN.
- Defined:
  - Extra output port Error (1 bit).
  - A consistency flag is captured at Go: Divisor==0 OR Remainder>=Divisor.
  - Error is asserted in the DONE cycle together with Done, and is 0 otherwise. Reset value 0.
  - Dividend is still computed normally.
- Not defined: no Error port, no flag register; behaviour otherwise identical.

Decomposition:
- Shared package (recon_pkg):
  - state encoding constants IDLE=2'd0, MULT=2'd1, ADD=2'd2, DONE=2'd3
  - default WIDTH constant
  - counter width function clog2(WIDTH+1)
- Natural sub-module: recon_datapath, holding acc, multiplicand, multiplier, counter and the final adder, driven by load/step/add strobes.
- Top level keeps the FSM and the handshake outputs.

Test Plan:
1. WIDTH=4, Q=3, D=4, R=2, Go pulse at edge N -> Busy during N+1..N+5; Dividend=14 and Done=1 after edge N+5; Done=0 after N+6.
2. Q=15, D=15, R=14 -> Dividend=239; Error=0 with RECON_CHECK_EN.
3. D=0, Q=7, R=5 -> Dividend=5, Error=1. Also Q=2, D=4, R=6 -> Dividend=14, Error=1 (Remainder>=Divisor).
4. Go held high continuously, operands changed every cycle while Busy -> starts exactly every 7 cycles; each result uses only the operands present at its start edge.
5. Resetn low for one edge during the 2nd MULT cycle -> next cycle Dividend=0, Busy=0, Done=0, state IDLE; a following Go completes correctly (Q=5, D=3, R=1 -> 16).
6. Q=0, D=9, R=8 -> Dividend=8 with full 6-edge latency; Dividend retains 8 while idle for 20 cycles.
